// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two requesters, the register file write port and decode hazard lookup.
// The slave modport is the arbiter side; the master modport drives the requests.
interface regfile_wb_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 4
);
  logic                  AValid;
  logic                  AReady;
  logic [ADDR_WIDTH-1:0] AReg;
  logic [DATA_WIDTH-1:0] AData;
  logic                  BValid;
  logic                  BReady;
  logic [ADDR_WIDTH-1:0] BReg;
  logic [DATA_WIDTH-1:0] BData;
  logic                  WriteReg;
  logic [ADDR_WIDTH-1:0] DstReg;
  logic [DATA_WIDTH-1:0] DstData;
  logic [ADDR_WIDTH-1:0] SrcReg1;
  logic [ADDR_WIDTH-1:0] SrcReg2;
  logic                  Hazard1;
  logic                  Hazard2;
  logic                  Idle;

  modport slave (
    input  AValid, AReg, AData, BValid, BReg, BData, SrcReg1, SrcReg2,
    output AReady, BReady, WriteReg, DstReg, DstData, Hazard1, Hazard2, Idle
  );

  modport master (
    output AValid, AReg, AData, BValid, BReg, BData, SrcReg1, SrcReg2,
    input  AReady, BReady, WriteReg, DstReg, DstData, Hazard1, Hazard2, Idle
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two-source register file writeback arbiter with per-source FIFOs and a pending-write scoreboard.
// Define RR_ARB_EN for round-robin arbitration; otherwise source B has fixed priority.
module regfile_wb_arbiter #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_wb_arbiter_if.slave  bus
);
  localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
  localparam int unsigned PW1      = PTR_W + 1;
  localparam int unsigned NUM_REGS = 1 << ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] r_a_reg  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_a_data [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] r_b_reg  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_b_data [FIFO_DEPTH];
  logic [PTR_W:0]        r_a_wr, r_a_rd, r_b_wr, r_b_rd;
  logic                  r_out_valid;
  logic [ADDR_WIDTH-1:0] r_out_reg;
  logic [DATA_WIDTH-1:0] r_out_data;
`ifdef RR_ARB_EN
  logic                  r_prefer_b;
`endif

  logic                  w_a_empty, w_b_empty, w_a_full, w_b_full;
  logic                  w_a_ready, w_b_ready, w_a_push, w_b_push;
  logic                  w_grant_a, w_grant_b;
  logic [PTR_W:0]        w_a_count, w_b_count;
  logic [NUM_REGS-1:0]   w_busy;

  // Extra pointer bit separates full from empty when the index bits match.
  assign w_a_empty = (r_a_wr == r_a_rd);
  assign w_b_empty = (r_b_wr == r_b_rd);
  assign w_a_full  = (r_a_wr[PTR_W] != r_a_rd[PTR_W]) && (r_a_wr[PTR_W-1:0] == r_a_rd[PTR_W-1:0]);
  assign w_b_full  = (r_b_wr[PTR_W] != r_b_rd[PTR_W]) && (r_b_wr[PTR_W-1:0] == r_b_rd[PTR_W-1:0]);
  assign w_a_count = r_a_wr - r_a_rd;
  assign w_b_count = r_b_wr - r_b_rd;

  assign w_a_ready = !rst && !w_a_full;
  assign w_b_ready = !rst && !w_b_full;
  assign w_a_push  = bus.AValid && w_a_ready && (bus.AReg != '0);
  assign w_b_push  = bus.BValid && w_b_ready && (bus.BReg != '0);

`ifdef RR_ARB_EN
  assign w_grant_a = !w_a_empty && (w_b_empty || !r_prefer_b);
`else
  assign w_grant_a = !w_a_empty && w_b_empty;
`endif
  assign w_grant_b = !w_b_empty && !w_grant_a;

  // FIFO storage, arbitration and the registered write stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_wr      <= '0;
      r_a_rd      <= '0;
      r_b_wr      <= '0;
      r_b_rd      <= '0;
      r_out_valid <= 1'b0;
      r_out_reg   <= '0;
      r_out_data  <= '0;
`ifdef RR_ARB_EN
      r_prefer_b  <= 1'b0;
`endif
    end else begin
      if (w_a_push) begin
        r_a_reg[r_a_wr[PTR_W-1:0]]  <= bus.AReg;
        r_a_data[r_a_wr[PTR_W-1:0]] <= bus.AData;
        r_a_wr                      <= r_a_wr + PW1'(1);
      end
      if (w_b_push) begin
        r_b_reg[r_b_wr[PTR_W-1:0]]  <= bus.BReg;
        r_b_data[r_b_wr[PTR_W-1:0]] <= bus.BData;
        r_b_wr                      <= r_b_wr + PW1'(1);
      end
      if (w_grant_a) begin
        r_out_valid <= 1'b1;
        r_out_reg   <= r_a_reg[r_a_rd[PTR_W-1:0]];
        r_out_data  <= r_a_data[r_a_rd[PTR_W-1:0]];
        r_a_rd      <= r_a_rd + PW1'(1);
`ifdef RR_ARB_EN
        r_prefer_b  <= 1'b1;
`endif
      end else if (w_grant_b) begin
        r_out_valid <= 1'b1;
        r_out_reg   <= r_b_reg[r_b_rd[PTR_W-1:0]];
        r_out_data  <= r_b_data[r_b_rd[PTR_W-1:0]];
        r_b_rd      <= r_b_rd + PW1'(1);
`ifdef RR_ARB_EN
        r_prefer_b  <= 1'b0;
`endif
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // A slot is occupied when its distance from the read index is below the count.
  always_comb begin
    w_busy = '0;
    if (r_out_valid) w_busy[r_out_reg] = 1'b1;
    for (int unsigned s = 0; s < FIFO_DEPTH; s++) begin
      if ({1'b0, PTR_W'(PTR_W'(s) - r_a_rd[PTR_W-1:0])} < w_a_count) w_busy[r_a_reg[s]] = 1'b1;
      if ({1'b0, PTR_W'(PTR_W'(s) - r_b_rd[PTR_W-1:0])} < w_b_count) w_busy[r_b_reg[s]] = 1'b1;
    end
  end

  assign bus.AReady   = w_a_ready;
  assign bus.BReady   = w_b_ready;
  assign bus.WriteReg = r_out_valid;
  assign bus.DstReg   = r_out_reg;
  assign bus.DstData  = r_out_data;
  assign bus.Hazard1  = w_busy[bus.SrcReg1] && (bus.SrcReg1 != '0);
  assign bus.Hazard2  = w_busy[bus.SrcReg2] && (bus.SrcReg2 != '0);
  assign bus.Idle     = w_a_empty && w_b_empty && !r_out_valid;
endmodule
